// File: rtl/adc_sample_ctrl.sv
// rtl/adc_sample_ctrl.sv - SAR ADC sequencer: conversion clock, result capture and result FIFO
module adc_sample_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 8,
    parameter int CONV_CYCLES = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              continuous,
    input  logic              start,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              adc_clock,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int PER_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PER_W-1:0] LAST_PER = PER_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_CAPTURE
    } state_t;

    state_t             r_state;
    state_t             w_state_n;

    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   r_half_cnt;
    logic [PER_W-1:0]   r_period;
    logic               r_phase_hi;
    logic               r_adc_clock;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_half_done;
    logic               w_conv_last;
    logic               w_load;
    logic               w_step;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_drop;

    // A conversion ends when the low half of the final adc_clock period completes.
    assign w_half_done = (r_half_cnt == r_div_q);
    assign w_conv_last = (r_state == S_CONVERT) && w_half_done && !r_phase_hi && (r_period == LAST_PER);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE without a capture.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && (start || continuous)) begin
                    w_state_n = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (!enable) begin
                    w_state_n = S_IDLE;
                end else if (w_conv_last) begin
                    w_state_n = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (enable && continuous) begin
                    w_state_n = S_CONVERT;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Entering CONVERT (from IDLE or back-to-back from CAPTURE) re-latches the divider.
    assign w_load = (w_state_n == S_CONVERT) && (r_state != S_CONVERT);
    assign w_step = (w_state_n == S_CONVERT) && (r_state == S_CONVERT);

    // Divider, period counter and registered adc_clock; the clock starts with its high half.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_q     <= '0;
            r_half_cnt  <= '0;
            r_period    <= '0;
            r_phase_hi  <= 1'b0;
            r_adc_clock <= 1'b0;
        end else if (w_load) begin
            r_div_q     <= clk_div;
            r_half_cnt  <= '0;
            r_period    <= '0;
            r_phase_hi  <= 1'b1;
            r_adc_clock <= 1'b1;
        end else if (w_step) begin
            if (w_half_done) begin
                r_half_cnt  <= '0;
                r_phase_hi  <= !r_phase_hi;
                r_adc_clock <= !r_phase_hi;
                if (!r_phase_hi) begin
                    r_period <= r_period + 1'b1;
                end
            end else begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end else begin
            r_half_cnt  <= '0;
            r_period    <= '0;
            r_phase_hi  <= 1'b0;
            r_adc_clock <= 1'b0;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = (r_state == S_CAPTURE) && enable;
    assign w_pop      = !w_empty && sample_ready;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Result storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign adc_clock    = r_adc_clock;
    assign busy         = (r_state != S_IDLE);
    assign sample_valid = !w_empty;
    assign sample_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb/tb_adc_sample_ctrl.sv - directed self-checking bench for adc_sample_ctrl
module tb_adc_sample_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       continuous;
    logic       start;
    logic [7:0] clk_div;
    logic       adc_clock;
    logic [7:0] adc_data;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] sample_data;
    logic       busy;
    logic       overflow;
    logic       clear_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk_s   [0:127];
    logic busy_s  [0:127];
    logic valid_s [0:127];

    logic       ovf_a;
    logic       ovf_b;
    logic [7:0] head;

    adc_sample_ctrl #(
        .DATA_W(8), .DIV_W(8), .CONV_CYCLES(10), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .continuous(continuous),
        .start(start), .clk_div(clk_div), .adc_clock(adc_clock), .adc_data(adc_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
        .busy(busy), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-shot conversion starting in cycle 0; clk_div is forced to 0 at cycle 20 to show it is ignored.
    task automatic run_conv(input logic [7:0] div, input logic [7:0] val, input string tag);
        int d, n, pulses, bad, first_v;
        logic exp_clk;
        logic [7:0] data_at_valid, data_after;
        d = int'(div);
        n = 2 * (d + 1) * 10;
        enable = 1'b1; continuous = 1'b0; clk_div = div; adc_data = val;
        start = 1'b1; sample_ready = 1'b0;
        data_at_valid = 8'h00; data_after = 8'hFF;
        for (int c = 0; c <= n + 3; c++) begin
            @(negedge clock);
            clk_s[c] = adc_clock; busy_s[c] = busy; valid_s[c] = sample_valid;
            if (c == n + 2) data_at_valid = sample_data;
            if (c == n + 3) data_after = sample_data;
            tick();
            start = 1'b0;
            if (c == 20) clk_div = 8'h00;
            sample_ready = (c + 1 == n + 2);
        end
        sample_ready = 1'b0;
        pulses = 0; bad = 0; first_v = -1;
        for (int c = 0; c <= n + 3; c++) begin
            if (c > 0 && clk_s[c] && !clk_s[c-1]) pulses++;
            exp_clk = (c >= 1 && c <= n) ? (((c - 1) / (d + 1)) % 2 == 0) : 1'b0;
            if (clk_s[c] !== exp_clk) bad++;
            if (valid_s[c] && first_v < 0) first_v = c;
        end
        check($sformatf("%s pulses", tag), pulses, 10);
        check($sformatf("%s clk_shape_errors", tag), bad, 0);
        check($sformatf("%s first_valid_cycle", tag), first_v, n + 2);
        check($sformatf("%s busy_c0", tag), busy_s[0], 1'b0);
        check($sformatf("%s busy_c1", tag), busy_s[1], 1'b1);
        check($sformatf("%s busy_last", tag), busy_s[n+1], 1'b1);
        check($sformatf("%s busy_after", tag), busy_s[n+2], 1'b0);
        check($sformatf("%s data", tag), data_at_valid, val);
        check($sformatf("%s valid_after_pop", tag), valid_s[n+3], 1'b0);
        check($sformatf("%s data_after_pop", tag), data_after, 8'h00);
    endtask

    // Continuous clk_div=0 run: captures at cycles 21,42,63,84,105 with data base+1..base+5; aborted at 106.
    task automatic run_cont(input logic [7:0] base, input int pop_cyc,
                            output logic o_ovf_a, output logic o_ovf_b, output logic [7:0] o_head);
        o_ovf_a = 1'bx; o_ovf_b = 1'bx; o_head = 8'hxx;
        enable = 1'b1; continuous = 1'b1; clk_div = 8'h00; start = 1'b0; sample_ready = 1'b0;
        for (int c = 0; c <= 106; c++) begin
            adc_data = base + 8'((c == 0) ? 1 : ((c - 1) / 21 + 1));
            sample_ready = (c == pop_cyc);
            if (c == 106) begin
                enable = 1'b0;
                continuous = 1'b0;
            end
            @(negedge clock);
            if (c == 85) begin
                o_ovf_a = overflow;
                o_head = sample_data;
            end
            if (c == 106) o_ovf_b = overflow;
            tick();
        end
        sample_ready = 1'b0;
    endtask

    task automatic drain(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input string tag);
        logic [7:0] got[$];
        logic [7:0] exp_v[4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        sample_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (sample_valid) got.push_back(sample_data);
            tick();
        end
        sample_ready = 1'b0;
        check($sformatf("%s count", tag), got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s entry%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp_v[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        reset_n = 1'b0; enable = 1'b0; continuous = 1'b0; start = 1'b0; clk_div = 8'h00;
        adc_data = 8'h00; sample_ready = 1'b0; clear_overflow = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset adc_clock", adc_clock, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset valid", sample_valid, 1'b0);
        check("reset data", sample_data, 8'h00);
        check("reset overflow", overflow, 1'b0);
        reset_n = 1'b1;
        tick();

        run_conv(8'd0, 8'hA5, "single");
        tick();
        run_conv(8'd3, 8'h3C, "div3");
        tick();

        run_cont(8'h00, -1, ovf_a, ovf_b, head);
        check("cont ovf_after4", ovf_a, 1'b0);
        check("cont head_after4", head, 8'h01);
        check("cont ovf_after5", ovf_b, 1'b1);
        drain(8'h01, 8'h02, 8'h03, 8'h04, "cont_drain");
        check("cont ovf_held", overflow, 1'b1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clock);
        check("cont ovf_cleared", overflow, 1'b0);
        tick();

        run_cont(8'h10, 105, ovf_a, ovf_b, head);
        check("fullpop head_after4", head, 8'h11);
        check("fullpop no_overflow", ovf_b, 1'b0);
        drain(8'h12, 8'h13, 8'h14, 8'h15, "fullpop_drain");

        bad = 0;
        enable = 1'b1; clk_div = 8'h00; start = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clock);
            if (c == 7) begin
                check("abort busy_c7", busy, 1'b1);
                check("abort clk_c7", adc_clock, 1'b1);
            end
            if (c == 8) begin
                check("abort clk_c8", adc_clock, 1'b0);
                check("abort busy_c8", busy, 1'b0);
            end
            if (c >= 8 && (busy || sample_valid)) bad++;
            tick();
            start = (c + 1 == 3) || (c + 1 == 10);
            enable = (c + 1 < 7);
        end
        start = 1'b0;
        check("abort idle_errors", bad, 0);

        run_cont(8'h20, -1, ovf_a, ovf_b, head);
        check("prereset ovf", ovf_b, 1'b1);
        enable = 1'b1; clk_div = 8'h00; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = 1'b0;
        end
        #2;
        check("prereset clk", adc_clock, 1'b1);
        check("prereset busy", busy, 1'b1);
        check("prereset valid", sample_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async clk", adc_clock, 1'b0);
        check("async busy", busy, 1'b0);
        check("async valid", sample_valid, 1'b0);
        check("async overflow", overflow, 1'b0);
        check("async data", sample_data, 8'h00);
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        check("postreset empty", sample_valid, 1'b0);
        tick();
        run_conv(8'd0, 8'hA5, "postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
